axis_rr_arbiter: RTL and testbench

AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

---
 rtl/axis_arb_pkg.sv | 20 ++
 rtl/rr_picker.sv | 33 +++
 rtl/axis_rr_arbiter.sv | 100 ++++++++++
 tb/tb_axis_rr_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared defaults, FSM encoding and pointer sizing for the round-robin stream arbiter.
// No logic; latency n/a.
// Backpressure n/a.
package axis_arb_pkg;

    localparam int N_PORTS_DEF = 4;
    localparam int DATA_W_DEF  = 8;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PTR_W_DEF = ptr_width(N_PORTS_DEF);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set request at or above ptr, wrapping modulo N.
// Purely combinational, zero latency.
// No backpressure; the caller qualifies req.
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [PW:0] cand;

    // Scan from farthest to nearest so the index closest to ptr is written last and wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (PW + 1)'(k);
            if (cand >= (PW + 1)'(N)) begin
                cand = cand - (PW + 1)'(N);
            end
            if (req[cand[PW-1:0]]) begin
                gnt_idx = cand[PW-1:0];
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-locked round-robin arbiter merging N_PORTS streams into one registered output.
// One cycle to arbitrate, one cycle input-to-output; one bubble between packets.
// Input ready follows output register space (!s_valid || s_ready); stalls hold the lock indefinitely.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int N_PORTS = N_PORTS_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_PORTS-1:0]           port_en,
    input  logic [N_PORTS*DATA_W-1:0]    m_data,
    input  logic [N_PORTS-1:0]           m_valid,
    input  logic [N_PORTS-1:0]           m_last,
    output logic [N_PORTS-1:0]           m_ready,
    output logic [DATA_W-1:0]            s_data,
    output logic                         s_valid,
    output logic                         s_last,
    input  logic                         s_ready,
    output logic [$clog2(N_PORTS)-1:0]   grant_id,
    output logic                         busy
);

    localparam int PW = $clog2(N_PORTS);

    arb_state_t          state;
    logic [PW-1:0]       rr_ptr;
    logic [PW-1:0]       gnt_idx;
    logic                gnt_vld;
    logic [N_PORTS-1:0]  req;
    logic                out_free;
    logic                accept;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_valid;
    logic                sel_last;

    assign busy = (state == LOCKED);

    // port_en only gates new arbitration; a locked packet ignores it.
    assign req = (state == IDLE) ? (m_valid & port_en) : '0;

    rr_picker #(
        .N  (N_PORTS),
        .PW (PW)
    ) u_picker (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign out_free  = !s_valid || s_ready;
    assign sel_data  = m_data[grant_id*DATA_W +: DATA_W];
    assign sel_valid = m_valid[grant_id];
    assign sel_last  = m_last[grant_id];
    assign accept    = busy && out_free && sel_valid;

    always_comb begin
        m_ready = '0;
        if (busy) begin
            m_ready[grant_id] = out_free;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            s_valid  <= 1'b0;
            s_last   <= 1'b0;
            s_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        grant_id <= gnt_idx;
                        state    <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (accept && sel_last) begin
                        state  <= IDLE;
                        rr_ptr <= (grant_id == PW'(N_PORTS - 1)) ? '0 : grant_id + 1'b1;
                    end
                end
            endcase

            if (accept) begin
                s_valid <= 1'b1;
                s_data  <= sel_data;
                s_last  <= sel_last;
            end else if (s_ready) begin
                s_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: directed scenarios then randomized traffic against a packet-level model.
module tb_axis_rr_arbiter;

    localparam int NP = 4;
    localparam int DW = 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic              clk;
    logic              rst_n;
    logic [NP-1:0]     port_en;
    logic [NP*DW-1:0]  m_data;
    logic [NP-1:0]     m_valid;
    logic [NP-1:0]     m_last;
    logic [NP-1:0]     m_ready;
    logic [DW-1:0]     s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic [1:0]        grant_id;
    logic              busy;

    axis_rr_arbiter #(.N_PORTS(NP), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .port_en  (port_en),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .grant_id (grant_id),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int miscompares = 0;

    beat_t src_q [NP][$];
    beat_t exp_q [$];
    int    grant_log [$];

    logic [NP-1:0] cur_v;
    int            m_ptr, m_gnt;
    bit            m_busy, m_sv, busy_seen, stalled;
    logic [DW-1:0] prev_d;
    logic          prev_l;
    int            rdy_pol, out_cnt;
    bit            gap, en_rand;
    logic [NP-1:0] en_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int pick(input logic [NP-1:0] r, input int p);
        for (int k = 0; k < NP; k++) begin
            if (r[(p + k) % NP]) return (p + k) % NP;
        end
        return 0;
    endfunction

    function automatic int pending();
        int n = exp_q.size() + int'(m_busy) + int'(m_sv);
        for (int p = 0; p < NP; p++) n += src_q[p].size();
        return n;
    endfunction

    task automatic add_beat(input int p, input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        src_q[p].push_back(b);
    endtask

    task automatic add_pkt(input int p, input int len);
        for (int i = 0; i < len; i++) add_beat(p, DW'($urandom), (i == len - 1));
    endtask

    task automatic drive();
        m_data  = '0;
        m_valid = '0;
        m_last  = '0;
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() != 0) begin
                if (!cur_v[p]) cur_v[p] = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
            end else begin
                cur_v[p] = 1'b0;
            end
            if (cur_v[p]) begin
                m_valid[p]           = 1'b1;
                m_data[p*DW +: DW]   = src_q[p][0].d;
                m_last[p]            = src_q[p][0].l;
            end
        end
        case (rdy_pol)
            0:       s_ready = 1'b1;
            1:       s_ready = 1'b0;
            default: s_ready = 1'($urandom_range(0, 1));
        endcase
        port_en = (en_rand && $urandom_range(0, 3) == 0) ? NP'($urandom) : en_val;
    endtask

    // One clock: check at the falling edge, then advance the model past the rising edge.
    task automatic step();
        logic [NP-1:0] exp_rdy, in_hs, req;
        logic          rdy_s, hs_last;
        @(negedge clk);
        exp_rdy = '0;
        if (m_busy && (!m_sv || s_ready)) exp_rdy[m_gnt] = 1'b1;
        chk("busy", busy, m_busy);
        if (m_busy) chk("grant_id", grant_id, m_gnt);
        chk("m_ready", m_ready, exp_rdy);
        chk("s_valid", s_valid, m_sv);
        if (stalled) chk("s_hold", {s_last, s_data}, {prev_l, prev_d});
        if (s_valid && s_ready) begin
            out_cnt++;
            chk("beat_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                chk("s_data", s_data, exp_q[0].d);
                chk("s_last", s_last, exp_q[0].l);
                void'(exp_q.pop_front());
            end
        end
        if (busy && !busy_seen) grant_log.push_back(int'(grant_id));
        busy_seen = busy;
        stalled   = s_valid && !s_ready;
        prev_d    = s_data;
        prev_l    = s_last;
        in_hs     = m_valid & m_ready;
        req       = m_valid & port_en;
        rdy_s     = s_ready;

        @(posedge clk);
        #1;
        hs_last = 1'b0;
        for (int p = 0; p < NP; p++) begin
            if (in_hs[p] && src_q[p].size() != 0) begin
                if (p == m_gnt) hs_last = src_q[p][0].l;
                void'(src_q[p].pop_front());
                cur_v[p] = 1'b0;
            end
        end
        m_sv = (m_sv && !rdy_s) || (in_hs != '0);
        if (!m_busy) begin
            if (req != '0) begin
                m_gnt  = pick(req, m_ptr);
                m_busy = 1'b1;
                for (int i = 0; i < src_q[m_gnt].size(); i++) begin
                    exp_q.push_back(src_q[m_gnt][i]);
                    if (src_q[m_gnt][i].l) break;
                end
            end
        end else if (in_hs[m_gnt] && hs_last) begin
            m_busy = 1'b0;
            m_ptr  = (m_gnt + 1) % NP;
        end
        drive();
    endtask

    task automatic drain(input int maxc, input string tag);
        int c = 0;
        while (pending() != 0 && c < maxc) begin
            step();
            c++;
        end
        chk(tag, pending(), 0);
    endtask

    task automatic rst_checks();
        chk("rst_busy", busy, 0);
        chk("rst_m_ready", m_ready, 0);
        chk("rst_s_valid", s_valid, 0);
        chk("rst_s_last", s_last, 0);
        chk("rst_s_data", s_data, 0);
        chk("rst_grant_id", grant_id, 0);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        rst_checks();
        for (int p = 0; p < NP; p++) src_q[p].delete();
        exp_q.delete();
        cur_v     = '0;
        m_busy    = 1'b0;
        m_sv      = 1'b0;
        m_ptr     = 0;
        m_gnt     = 0;
        stalled   = 1'b0;
        busy_seen = 1'b0;
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive();
    endtask

    initial begin
        int c, base;
        rst_n = 1'b1; port_en = '0; m_data = '0; m_valid = '0; m_last = '0; s_ready = 1'b0;
        cur_v = '0; en_val = '1; rdy_pol = 0; gap = 1'b0; en_rand = 1'b0; out_cnt = 0;
        m_ptr = 0; m_gnt = 0; m_busy = 1'b0; m_sv = 1'b0; busy_seen = 1'b0; stalled = 1'b0;
        prev_d = '0; prev_l = 1'b0;

        // Reset asserted before any clock edge: outputs must already be cleared.
        #2 rst_n = 1'b0;
        #1;
        rst_checks();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive();

        // Port 2 three-beat packet, then ports 0 and 3 compete with the pointer at 3.
        grant_log.delete();
        add_beat(2, 8'h11, 1'b0);
        add_beat(2, 8'h22, 1'b0);
        add_beat(2, 8'h33, 1'b1);
        drain(50, "s1_drain");
        add_beat(0, 8'h40, 1'b1);
        add_beat(3, 8'h43, 1'b1);
        drain(50, "s1b_drain");
        chk("s1_log_size", grant_log.size(), 3);
        if (grant_log.size() == 3) begin
            chk("s1_grant0", grant_log[0], 2);
            chk("s1_grant1", grant_log[1], 3);
            chk("s1_grant2", grant_log[2], 0);
        end

        // Output stall on port 1 with 0xA5 held for three cycles.
        rdy_pol = 1;
        add_beat(1, 8'hA5, 1'b0);
        add_beat(1, 8'h5A, 1'b1);
        drive();
        c = 0;
        while (!s_valid && c < 20) begin
            step();
            c++;
        end
        chk("s3_valid_seen", s_valid, 1);
        base = out_cnt;
        repeat (3) begin
            chk("s3_hold_valid", s_valid, 1);
            chk("s3_hold_data", s_data, 8'hA5);
            chk("s3_m_ready_low", m_ready, 0);
            step();
        end
        rdy_pol = 0;
        drive();
        drain(50, "s3_drain");
        chk("s3_beats", out_cnt - base, 2);

        // Pointer now 2; port 2 disabled so port 3 wins, then port 3 is disabled mid-packet.
        grant_log.delete();
        en_val = 4'b1011;
        add_beat(2, 8'h21, 1'b0);
        add_beat(2, 8'h22, 1'b1);
        add_beat(3, 8'h31, 1'b0);
        add_beat(3, 8'h32, 1'b0);
        add_beat(3, 8'h33, 1'b1);
        drive();
        c = 0;
        while (!busy && c < 20) begin
            step();
            c++;
        end
        chk("s4_grant", grant_id, 3);
        en_val = 4'b0011;
        drive();
        c = 0;
        while ((src_q[3].size() != 0 || m_busy || m_sv || exp_q.size() != 0) && c < 50) begin
            step();
            c++;
        end
        chk("s4_port3_done", src_q[3].size(), 0);
        chk("s4_port2_waiting", src_q[2].size(), 2);
        en_val = 4'b0000;
        drive();
        repeat (5) step();
        chk("s4_disabled_idle", busy, 0);
        en_val = '1;
        drive();
        drain(50, "s4_drain");
        chk("s4_log_size", grant_log.size(), 2);
        if (grant_log.size() == 2) chk("s4_second_grant", grant_log[1], 2);

        // Single-beat packet.
        base = out_cnt;
        add_beat(0, 8'h7E, 1'b1);
        drain(30, "s6_drain");
        chk("s6_beats", out_cnt - base, 1);
        chk("s6_idle", busy, 0);

        // Asynchronous reset in the middle of a port 1 packet.
        base = out_cnt;
        add_pkt(1, 4);
        c = 0;
        while (out_cnt == base && c < 20) begin
            step();
            c++;
        end
        chk("s5_mid_packet", busy, 1);
        async_reset();
        grant_log.delete();
        add_beat(0, 8'h50, 1'b1);
        add_beat(3, 8'h53, 1'b1);
        drain(50, "s5_drain");
        chk("s5_log_size", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("s5_grant0", grant_log[0], 0);
            chk("s5_grant1", grant_log[1], 3);
        end

        // All four ports with back-to-back two-beat packets.
        grant_log.delete();
        for (int p = 0; p < NP; p++) begin
            add_pkt(p, 2);
            add_pkt(p, 2);
        end
        drain(200, "s2_drain");
        chk("s2_log_size", grant_log.size(), 8);
        if (grant_log.size() == 8) begin
            chk("s2_g0", grant_log[0], 0);
            chk("s2_g1", grant_log[1], 1);
            chk("s2_g2", grant_log[2], 2);
            chk("s2_g3", grant_log[3], 3);
            chk("s2_g4", grant_log[4], 0);
        end

        // Randomized traffic: valid gaps, random downstream ready, occasional port_en masking.
        rdy_pol = 2;
        gap     = 1'b1;
        en_rand = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            c = 0;
            for (int p = 0; p < NP; p++) c += src_q[p].size();
            if (c < 8) add_pkt($urandom_range(0, NP - 1), $urandom_range(1, 4));
            step();
        end
        en_rand = 1'b0;
        en_val  = '1;
        drain(3000, "rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
